rob: RTL and testbench

ROB -- requirements
Module: rob

---
 rtl/rob.sv | 183 ++++++++++++++++++
 tb/tb_rob.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob.sv
// Reorder buffer: 4-wide in-order dispatch/commit, WB_PORTS result writeback, 8 operand read ports.
// Optional macro ROB_WB_BYPASS_EN forwards same-cycle writebacks onto the read ports.
module rob #(
  parameter int ROB_DEPTH     = 64,
  parameter int ROB_IDX_WIDTH = $clog2(ROB_DEPTH),
  parameter int XLEN          = 32,
  parameter int WB_PORTS      = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [3:0]                             disp_valid_i,
  input  logic [3:0]                             disp_we_i,
  input  logic [3:0][4:0]                        disp_rd_idx_i,
  output logic                                   disp_ready_o,
  output logic [3:0][ROB_IDX_WIDTH-1:0]          disp_rob_idx_o,
  input  logic [WB_PORTS-1:0]                    wb_valid_i,
  input  logic [WB_PORTS-1:0][ROB_IDX_WIDTH-1:0] wb_rob_idx_i,
  input  logic [WB_PORTS-1:0][XLEN-1:0]          wb_data_i,
  input  logic [WB_PORTS-1:0]                    wb_exc_i,
  input  logic [7:0][ROB_IDX_WIDTH-1:0]          rd_rob_idx_i,
  output logic [7:0]                             rd_ready_o,
  output logic [7:0][XLEN-1:0]                   rd_data_o,
  output logic [3:0]                             commit_valid_o,
  output logic [3:0]                             commit_we_o,
  output logic [3:0][4:0]                        commit_rd_idx_o,
  output logic [3:0][ROB_IDX_WIDTH-1:0]          commit_rob_idx_o,
  output logic [3:0][XLEN-1:0]                   commit_data_o,
  output logic                                   flush_o
);
  localparam int IW = ROB_IDX_WIDTH;
  typedef logic [IW-1:0] idx_t;
  typedef logic [IW:0]   ptr_t;
  localparam ptr_t READY_LIMIT = ptr_t'(ROB_DEPTH - 4);

  logic [ROB_DEPTH-1:0]           valid_q, valid_d, done_q, done_d, exc_q, exc_d, we_q, we_d;
  logic [ROB_DEPTH-1:0][4:0]      rd_q, rd_d;
  logic [ROB_DEPTH-1:0][XLEN-1:0] data_q, data_d;
  ptr_t                           head_q, head_d, tail_q, tail_d;
  ptr_t                           count;
  logic [2:0]                     n_acc, n_cmt;

  // The wrap bit makes tail - head span 0..ROB_DEPTH without ambiguity between full and empty.
  assign count        = tail_q - head_q;
  assign disp_ready_o = (count <= READY_LIMIT) && !flush_o;

  always_comb begin
    logic [2:0] below;
    below = '0;
    for (int i = 0; i < 4; i++) begin
      disp_rob_idx_o[i] = tail_q[IW-1:0] + idx_t'(below);
      below = below + {2'b0, disp_valid_i[i]};
    end
  end

  // Commit window: the first lane that is not a clean completed entry closes it.
  always_comb begin
    logic chain;
    idx_t cidx;
    commit_valid_o   = '0;
    commit_we_o      = '0;
    commit_rd_idx_o  = '0;
    commit_rob_idx_o = '0;
    commit_data_o    = '0;
    flush_o          = 1'b0;
    chain            = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cidx = head_q[IW-1:0] + idx_t'(k);
      if (chain) begin
        if (valid_q[cidx] && done_q[cidx] && !exc_q[cidx]) begin
          commit_valid_o[k]   = 1'b1;
          commit_we_o[k]      = we_q[cidx] && (rd_q[cidx] != 5'd0);
          commit_rd_idx_o[k]  = rd_q[cidx];
          commit_rob_idx_o[k] = cidx;
          commit_data_o[k]    = data_q[cidx];
        end else begin
          flush_o = valid_q[cidx] && done_q[cidx] && exc_q[cidx];
          chain   = 1'b0;
        end
      end
    end
  end

  always_comb begin
    n_acc = '0;
    n_cmt = '0;
    for (int i = 0; i < 4; i++) begin
      n_acc = n_acc + {2'b0, disp_valid_i[i]};
      n_cmt = n_cmt + {2'b0, commit_valid_o[i]};
    end
    if (!disp_ready_o) n_acc = '0;
  end

  always_comb begin
    idx_t ridx;
    for (int j = 0; j < 8; j++) begin
      ridx          = rd_rob_idx_i[j];
      rd_ready_o[j] = valid_q[ridx] && done_q[ridx];
      rd_data_o[j]  = valid_q[ridx] ? data_q[ridx] : '0;
`ifdef ROB_WB_BYPASS_EN
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
        if (valid_q[ridx] && wb_valid_i[p] && (wb_rob_idx_i[p] == ridx)) begin
          rd_ready_o[j] = 1'b1;
          rd_data_o[j]  = wb_data_i[p];
        end
      end
`endif
    end
  end

  // Update order: writeback, then dispatch into free slots, then retire the committed head entries.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    exc_d   = exc_q;
    we_d    = we_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_o) begin
      valid_d = '0;
      done_d  = '0;
      exc_d   = '0;
      we_d    = '0;
      rd_d    = '0;
      data_d  = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
        if (wb_valid_i[p] && valid_q[wb_rob_idx_i[p]]) begin
          done_d[wb_rob_idx_i[p]] = 1'b1;
          exc_d[wb_rob_idx_i[p]]  = wb_exc_i[p];
          data_d[wb_rob_idx_i[p]] = wb_data_i[p];
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (disp_ready_o && disp_valid_i[i]) begin
          valid_d[disp_rob_idx_o[i]] = 1'b1;
          done_d[disp_rob_idx_o[i]]  = 1'b0;
          exc_d[disp_rob_idx_o[i]]   = 1'b0;
          we_d[disp_rob_idx_o[i]]    = disp_we_i[i];
          rd_d[disp_rob_idx_o[i]]    = disp_rd_idx_i[i];
          data_d[disp_rob_idx_o[i]]  = '0;
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (commit_valid_o[k]) begin
          valid_d[commit_rob_idx_o[k]] = 1'b0;
          done_d[commit_rob_idx_o[k]]  = 1'b0;
          exc_d[commit_rob_idx_o[k]]   = 1'b0;
          we_d[commit_rob_idx_o[k]]    = 1'b0;
          rd_d[commit_rob_idx_o[k]]    = '0;
          data_d[commit_rob_idx_o[k]]  = '0;
        end
      end
      head_d = head_q + ptr_t'(n_cmt);
      tail_d = tail_q + ptr_t'(n_acc);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
      we_q    <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end
endmodule

// File: tb/tb_rob.sv
// Bench for rob: the ROB is modelled as an in-order queue of instructions; honours ROB_WB_BYPASS_EN.
module tb_rob;
  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           disp_valid, disp_we;
  logic [3:0][4:0]      disp_rd;
  logic                 disp_ready;
  logic [3:0][5:0]      disp_idx;
  logic [3:0]           wb_valid, wb_exc;
  logic [3:0][5:0]      wb_idx;
  logic [3:0][31:0]     wb_data;
  logic [7:0][5:0]      rd_idx;
  logic [7:0]           rd_ready;
  logic [7:0][31:0]     rd_data;
  logic [3:0]           c_valid, c_we;
  logic [3:0][4:0]      c_rd;
  logic [3:0][5:0]      c_idx;
  logic [3:0][31:0]     c_data;
  logic                 flush;

  int n_vec = 0;
  int n_err = 0;

  rob dut (
    .clk_i(clk), .rst_i(rst),
    .disp_valid_i(disp_valid), .disp_we_i(disp_we), .disp_rd_idx_i(disp_rd),
    .disp_ready_o(disp_ready), .disp_rob_idx_o(disp_idx),
    .wb_valid_i(wb_valid), .wb_rob_idx_i(wb_idx), .wb_data_i(wb_data), .wb_exc_i(wb_exc),
    .rd_rob_idx_i(rd_idx), .rd_ready_o(rd_ready), .rd_data_o(rd_data),
    .commit_valid_o(c_valid), .commit_we_o(c_we), .commit_rd_idx_o(c_rd),
    .commit_rob_idx_o(c_idx), .commit_data_o(c_data), .flush_o(flush)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct {
    int        idx;
    bit        we;
    bit [4:0]  rd;
    bit        done;
    bit        exc;
    bit [31:0] data;
  } ent_t;

  ent_t m_q[$];
  int   m_tail = 0;
  bit   m_live = 0;

  function automatic int m_head();
    return (m_tail - m_q.size() + 64) % 64;
  endfunction

  function automatic int m_ncmt();
    int n = 0;
    while (n < 4 && n < m_q.size() && m_q[n].done && !m_q[n].exc) n++;
    return n;
  endfunction

  function automatic bit m_flush();
    int n = m_ncmt();
    return (n < 4) && (n < m_q.size()) && m_q[n].done && m_q[n].exc;
  endfunction

  function automatic bit m_ready();
    return (64 - m_q.size() >= 4) && !m_flush();
  endfunction

  function automatic int m_find(int idx);
    for (int i = 0; i < m_q.size(); i++) if (m_q[i].idx == idx) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    int n;
    int pos;
    bit rdy;
    ent_t e;
    if (rst) begin
      m_q.delete();
      m_tail = 0;
      m_live = 1;
    end else if (m_live) begin
      if (m_flush()) begin
        m_q.delete();
        m_tail = 0;
      end else begin
        n   = m_ncmt();
        rdy = m_ready();
        for (int p = 3; p >= 0; p--) begin
          if (wb_valid[p]) begin
            pos = m_find(int'(wb_idx[p]));
            if (pos >= 0) begin
              m_q[pos].done = 1;
              m_q[pos].exc  = wb_exc[p];
              m_q[pos].data = wb_data[p];
            end
          end
        end
        if (rdy) begin
          for (int i = 0; i < 4; i++) begin
            if (disp_valid[i]) begin
              e.idx = m_tail; e.we = disp_we[i]; e.rd = disp_rd[i];
              e.done = 0; e.exc = 0; e.data = 0;
              m_q.push_back(e);
              m_tail = (m_tail + 1) % 64;
            end
          end
        end
        repeat (n) void'(m_q.pop_front());
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input int lane, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got %h want %h at %0t", nm, lane, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int n, below, pos, h;
    bit e_rdy;
    logic [31:0] e_dat;
    if (m_live) begin
      chk("disp_ready", 0, disp_ready, m_ready());
      if (m_ready()) begin
        below = 0;
        for (int i = 0; i < 4; i++) begin
          chk("disp_idx", i, disp_idx[i], (m_tail + below) % 64);
          below += disp_valid[i];
        end
      end
      n = m_ncmt();
      h = m_head();
      for (int k = 0; k < 4; k++) begin
        chk("commit_valid", k, c_valid[k], k < n);
        if (k < n) begin
          chk("commit_we", k, c_we[k], m_q[k].we && (m_q[k].rd != 0));
          chk("commit_rd", k, c_rd[k], m_q[k].rd);
          chk("commit_idx", k, c_idx[k], (h + k) % 64);
          chk("commit_data", k, c_data[k], m_q[k].data);
        end else begin
          chk("commit_we_idle", k, c_we[k], 0);
        end
      end
      chk("flush", 0, flush, m_flush());
      for (int j = 0; j < 8; j++) begin
        pos = m_find(int'(rd_idx[j]));
        e_rdy = 0;
        e_dat = 0;
        if (pos >= 0) begin
          e_rdy = m_q[pos].done;
          e_dat = m_q[pos].done ? m_q[pos].data : 32'd0;
`ifdef ROB_WB_BYPASS_EN
          for (int p = 3; p >= 0; p--) begin
            if (wb_valid[p] && int'(wb_idx[p]) == int'(rd_idx[j])) begin
              e_rdy = 1;
              e_dat = wb_data[p];
            end
          end
`endif
        end
        chk("rd_ready", j, rd_ready[j], e_rdy);
        chk("rd_data", j, rd_data[j], e_dat);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = '0;
    disp_we    = '0;
    wb_valid   = '0;
    wb_exc     = '0;
  endtask

  task automatic disp(input logic [3:0] v);
    disp_valid = v;
    disp_we    = 4'($urandom);
    for (int i = 0; i < 4; i++) disp_rd[i] = 5'($urandom);
  endtask

  task automatic wb(input int p, input int idx, input logic [31:0] d, input bit e);
    wb_valid[p] = 1'b1;
    wb_idx[p]   = 6'(idx);
    wb_data[p]  = d;
    wb_exc[p]   = e;
  endtask

  task automatic drain();
    int c;
    int p;
    c = 0;
    while (m_q.size() > 0 && c < 300) begin
      idle();
      p = 0;
      for (int i = 0; i < m_q.size() && p < 4; i++) begin
        if (!m_q[i].done) begin
          wb(p, m_q[i].idx, $urandom, 0);
          p++;
        end
      end
      tick();
      c++;
    end
    idle();
    n_vec++;
    if (m_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout got %0d entries want 0", m_q.size());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int thr;
    rst = 1'b1;
    idle();
    disp_rd = '0;
    wb_idx  = '0;
    wb_data = '0;
    rd_idx  = '0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_disp_ready", 0, disp_ready, 1);
    chk("rst_commit_valid", 0, c_valid, 0);
    chk("rst_flush", 0, flush, 0);
    chk("rst_rd_ready", 0, rd_ready, 0);
    chk("rst_commit_data", 0, c_data[0], 0);
    tick();

    // Four-lane group after reset gets entries 0..3.
    disp_valid = 4'hF; disp_we = 4'hF;
    disp_rd[0] = 5'd1; disp_rd[1] = 5'd2; disp_rd[2] = 5'd3; disp_rd[3] = 5'd4;
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk("lit_grp_idx", i, disp_idx[i], i);
    tick();
    idle();
    @(negedge clk);
    chk("lit_no_commit", 0, c_valid, 0);
    chk("lit_tail4", 0, disp_idx[0], 4);
    disp_valid = 4'b0001; disp_we = 4'b0001; disp_rd[0] = 5'd5;
    tick();
    // Sparse lanes: tail=5.
    disp_valid = 4'b1010; disp_we = 4'b1010; disp_rd[1] = 5'd6; disp_rd[3] = 5'd7;
    @(negedge clk);
    chk("lit_sparse_l1", 1, disp_idx[1], 5);
    chk("lit_sparse_l3", 3, disp_idx[3], 6);
    tick();
    idle();
    @(negedge clk);
    chk("lit_tail7", 0, disp_idx[0], 7);

    // Out-of-order completion; entry 2 blocks entry 3.
    wb(0, 1, 32'hA, 0); wb(1, 0, 32'hB, 0); wb(2, 3, 32'hC, 0);
    tick();
    idle();
    @(negedge clk);
    chk("lit_cv_0011", 0, c_valid, 4'b0011);
    chk("lit_cdata0", 0, c_data[0], 32'hB);
    chk("lit_cdata1", 1, c_data[1], 32'hA);
    chk("lit_crd1", 1, c_rd[1], 2);
    tick();
    wb(3, 2, 32'hD, 0);
    tick();
    idle();
    @(negedge clk);
    chk("lit_cv_late", 0, c_valid, 4'b0011);
    chk("lit_cidx0", 0, c_idx[0], 2);
    chk("lit_cdata_d", 0, c_data[0], 32'hD);
    chk("lit_cdata_c", 1, c_data[1], 32'hC);
    tick();
    // Two ports hitting entry 4: port 0 wins.
    wb(0, 4, 32'h11, 0); wb(1, 4, 32'h22, 1);
    tick();
    idle();
    @(negedge clk);
    chk("lit_dup_cv", 0, c_valid, 4'b0001);
    chk("lit_dup_data", 0, c_data[0], 32'h11);
    tick();
    drain();

    // Fill to 61 with head=7, crossing the index wrap.
    for (int g = 0; g < 15; g++) begin
      disp(4'hF);
      tick();
    end
    idle();
    @(negedge clk);
    chk("lit_ready60", 0, disp_ready, 1);
    disp(4'b0001);
    tick();
    disp(4'hF);
    wb(0, 7, 32'h33, 0);
    @(negedge clk);
    chk("lit_ready61", 0, disp_ready, 0);
    tick();
    idle();
    @(negedge clk);
    chk("lit_full_cv", 0, c_valid, 4'b0001);
    chk("lit_full_cidx", 0, c_idx[0], 7);
    chk("lit_ready_same", 0, disp_ready, 0);
    tick();
    @(negedge clk);
    chk("lit_ready_after", 0, disp_ready, 1);
    chk("lit_tail_wrap", 0, disp_idx[0], 4);
    tick();
    drain();

    // Mid-operation reset.
    disp(4'hF);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("lit_mid_rst_cv", 0, c_valid, 0);
    chk("lit_mid_rst_tail", 0, disp_idx[0], 0);
    disp_valid = 4'b0011; disp_we = 4'b0011; disp_rd[0] = 5'd8; disp_rd[1] = 5'd9;
    tick();
    idle();
    wb(0, 0, 32'h77, 0); wb(1, 1, 32'h99, 1);
    tick();
    idle();
    disp(4'hF);
    wb(0, 0, 32'h1234, 0);
    @(negedge clk);
    chk("lit_exc_cv", 0, c_valid, 4'b0001);
    chk("lit_exc_data", 0, c_data[0], 32'h77);
    chk("lit_flush", 0, flush, 1);
    chk("lit_flush_ready", 0, disp_ready, 0);
    tick();
    idle();
    @(negedge clk);
    chk("lit_postflush", 0, flush, 0);
    chk("lit_postflush_cv", 0, c_valid, 0);
    chk("lit_postflush_rdy", 0, disp_ready, 1);
    chk("lit_postflush_tail", 0, disp_idx[0], 0);

    // Operand read of entry 7 with same-cycle writeback.
    disp(4'hF);
    tick();
    disp(4'hF);
    tick();
    idle();
    rd_idx[0] = 6'd7;
    wb(2, 7, 32'h55, 0);
    @(negedge clk);
`ifdef ROB_WB_BYPASS_EN
    chk("lit_byp_ready", 0, rd_ready[0], 1);
    chk("lit_byp_data", 0, rd_data[0], 32'h55);
`else
    chk("lit_byp_ready", 0, rd_ready[0], 0);
    chk("lit_byp_data", 0, rd_data[0], 0);
`endif
    tick();
    idle();
    @(negedge clk);
    chk("lit_rd_next_ready", 0, rd_ready[0], 1);
    chk("lit_rd_next_data", 0, rd_data[0], 32'h55);
    tick();
    drain();

    // Random phase: slow writeback first to build occupancy, then fast.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 599) == 0);
      disp(4'($urandom));
      thr = (cyc < 1500) ? 1 : 3;
      for (int p = 0; p < 4; p++) begin
        wb_valid[p] = ($urandom_range(0, 3) < thr);
        if (m_q.size() > 0 && $urandom_range(0, 7) != 0)
          wb_idx[p] = 6'(m_q[$urandom_range(0, m_q.size() - 1)].idx);
        else
          wb_idx[p] = 6'($urandom_range(0, 63));
        wb_data[p] = $urandom;
        wb_exc[p]  = (cyc < 1500) ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 49) == 0);
      end
      for (int j = 0; j < 8; j++) begin
        if (m_q.size() > 0 && $urandom_range(0, 1) == 1)
          rd_idx[j] = 6'(m_q[$urandom_range(0, m_q.size() - 1)].idx);
        else
          rd_idx[j] = 6'($urandom_range(0, 63));
      end
      tick();
    end
    rst = 1'b0;
    idle();
    drain();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
